// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: PC register, next-PC selection and the IF/ID pipeline
// register of a 5-stage MIPS pipeline.
// Each edge applies one action with priority Flush > Stall > Advance.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating stall and flush
// counters (parameter CNT_W, ports Stall_Cnt / Flush_Cnt).

module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [31:0]       Redirect_PC,
  input  logic [31:0]       IMem_Data,
  output logic [31:0]       IMem_Addr,
  output logic [31:0]       IFID_IR,
  output logic [31:0]       IFID_PCP4,
  output logic              IFID_Valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  Stall_Cnt,
  output logic [CNT_W-1:0]  Flush_Cnt
`endif
);

  localparam int unsigned ADDR_W = 32;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              unused_redirect_lsbs;

  // Sequential fall-through address; wraps modulo 2^32 with no flag.
  assign pc_plus4 = IMem_Addr + ADDR_W'(4);

  // Redirect targets are word aligned; the two low bits are dropped.
  assign redirect_aligned     = {Redirect_PC[31:2], 2'b00};
  assign unused_redirect_lsbs = ^Redirect_PC[1:0];

  // PC register: Flush redirects, Stall holds, otherwise step by one word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IMem_Addr <= RESET_PC;
    end else if (Flush) begin
      IMem_Addr <= redirect_aligned;
    end else if (!Stall) begin
      IMem_Addr <= pc_plus4;
    end
  end

  // IF/ID register: Flush inserts a bubble, Stall holds, otherwise capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IFID_IR    <= NOP_WORD;
      IFID_PCP4  <= '0;
      IFID_Valid <= 1'b0;
    end else if (Flush) begin
      IFID_IR    <= NOP_WORD;
      IFID_PCP4  <= '0;
      IFID_Valid <= 1'b0;
    end else if (!Stall) begin
      IFID_IR    <= IMem_Data;
      IFID_PCP4  <= pc_plus4;
      IFID_Valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating event counters; a flushing edge never counts as a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else if (Flush) begin
      if (Flush_Cnt != CNT_MAX) begin
        Flush_Cnt <= Flush_Cnt + CNT_W'(1);
      end
    end else if (Stall) begin
      if (Stall_Cnt != CNT_MAX) begin
        Stall_Cnt <= Stall_Cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
